// File: rtl/pool_reader.sv
// Drains one word from the TRNG bit pool and streams it out LSB byte first; POOL_READER_HEADER_EN prepends byte 8'hA5.
// Latency: start -> pool_enable next edge; pool_full sampled -> out_valid two edges later; one byte per cycle.
// Backpressure: out_data and out_valid hold while out_ready is low; start is only sampled in IDLE.
module pool_reader #(
  parameter int POOL_WIDTH = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pool_full,
  input  logic [POOL_WIDTH-1:0] pool_data,
  output logic                  pool_enable,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = (POOL_WIDTH + 7) / 8;
  localparam int WORD_W    = 8 * NUM_BYTES;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LATCH,
    S_SEND,
    S_FIN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         data_byte;

`ifdef POOL_READER_HEADER_EN
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  logic hdr_q;
`endif

  // Zero-extension on latch makes padding bits in the top byte read as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef POOL_READER_HEADER_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_LATCH) begin
        word_q <= WORD_W'(pool_data);
        idx_q  <= '0;
`ifdef POOL_READER_HEADER_EN
        hdr_q  <= 1'b1;
`endif
      end else if (state_q == S_SEND && out_ready) begin
`ifdef POOL_READER_HEADER_EN
        if (hdr_q) begin
          hdr_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
`else
        idx_q <= idx_q + 1'b1;
`endif
      end
    end
  end

  always_comb begin
    data_byte = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) begin
        data_byte = word_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pool_enable = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        pool_enable = 1'b1;
        if (pool_full) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
`ifdef POOL_READER_HEADER_EN
        out_data = hdr_q ? HDR_BYTE : data_byte;
        if (out_ready && !hdr_q && idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end
`else
        out_data = data_byte;
        if (out_ready && idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end
`endif
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pool_reader.sv
// Directed bench for pool_reader: 12-bit and 16-bit instances, each fed by a negedge pool model.
module tb_pool_reader;

  localparam int FILL_CYC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset     = 1'b1;
  logic start_drv = 1'b0;
  logic ready_drv = 1'b0;
  logic sel16     = 1'b0;

  int total = 0;
  int bad   = 0;

  logic        start12, full12, en12, valid12, ready12, busy12, done12;
  logic [7:0]  data12;
  logic [11:0] val12 = '0;
  int          cnt12 = 0;

  logic        start16, full16, en16, valid16, ready16, busy16, done16;
  logic [7:0]  data16;
  logic [15:0] val16 = '0;
  int          cnt16 = 0;

  assign start12 = start_drv & ~sel16;
  assign ready12 = ready_drv & ~sel16;
  assign start16 = start_drv & sel16;
  assign ready16 = ready_drv & sel16;

  pool_reader #(.POOL_WIDTH(12)) dut12 (
    .clock(clk), .reset(reset), .start(start12), .pool_full(full12), .pool_data(val12),
    .pool_enable(en12), .out_data(data12), .out_valid(valid12), .out_ready(ready12),
    .busy(busy12), .done(done12)
  );

  pool_reader #(.POOL_WIDTH(16)) dut16 (
    .clock(clk), .reset(reset), .start(start16), .pool_full(full16), .pool_data(val16),
    .pool_enable(en16), .out_data(data16), .out_valid(valid16), .out_ready(ready16),
    .busy(busy16), .done(done16)
  );

  // Pool models: count while enabled, clear when disabled, update on negedge.
  always @(negedge clk) begin
    if (!en12) cnt12 = 0;
    else if (cnt12 < FILL_CYC) cnt12 = cnt12 + 1;
    if (!en16) cnt16 = 0;
    else if (cnt16 < FILL_CYC) cnt16 = cnt16 + 1;
  end
  assign full12 = (cnt12 == FILL_CYC);
  assign full16 = (cnt16 == FILL_CYC);

  logic       obs_valid, obs_en, obs_busy, obs_done, obs_full;
  logic [7:0] obs_data;
  assign obs_valid = sel16 ? valid16 : valid12;
  assign obs_en    = sel16 ? en16    : en12;
  assign obs_busy  = sel16 ? busy16  : busy12;
  assign obs_done  = sel16 ? done16  : done12;
  assign obs_full  = sel16 ? full16  : full12;
  assign obs_data  = sel16 ? data16  : data12;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  done_cnt, done_at, en_first, valid_first, stall_bad, en_after_done;
  logic busy_last, full_at0, timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request; records transfers and timing. Iteration i samples the state after edge i.
  task automatic run_word(input int start_cycles, input int rdy_mode, input int tail, input int max_cyc);
    logic prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    done_cnt = 0; done_at = -1; en_first = -1; valid_first = -1;
    stall_bad = 0; en_after_done = 0; timed_out = 1'b1; busy_last = 1'b1;
    full_at0 = obs_full;
    prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < max_cyc; i++) begin
      start_drv = (i < start_cycles);
      ready_drv = (rdy_mode == 1) ? (i % 2 == 1) : 1'b1;
      if (obs_en && en_first < 0) en_first = i;
      if (obs_en && done_at >= 0) en_after_done++;
      if (obs_valid && valid_first < 0) valid_first = i;
      if (prev_stall && (!obs_valid || obs_data !== prev_data)) stall_bad++;
      if (obs_valid && ready_drv) got_q.push_back(obs_data);
      prev_stall = obs_valid && !ready_drv;
      prev_data  = obs_data;
      if (obs_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      busy_last = obs_busy;
      if (done_at >= 0 && i >= start_cycles && i >= done_at + tail) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    start_drv = 1'b0;
    ready_drv = 1'b0;
    step();
  endtask

  task automatic set_expect(input logic [15:0] word, input int nbytes);
    exp_q.delete();
`ifdef POOL_READER_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < nbytes; k++) begin
      exp_q.push_back(word[8*k +: 8]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_drv = 1'b1; ready_drv = 1'b1;
    repeat (3) step();
    total++;
    if ({en12, valid12, busy12, done12} !== 4'b0 || data12 !== 8'h00) begin
      bad++;
      $display("FAIL reset12 got en/v/busy/done=%b data=%h want 0000 00", {en12, valid12, busy12, done12}, data12);
    end
    total++;
    if ({en16, valid16, busy16, done16} !== 4'b0 || data16 !== 8'h00) begin
      bad++;
      $display("FAIL reset16 got en/v/busy/done=%b data=%h want 0000 00", {en16, valid16, busy16, done16}, data16);
    end
    reset = 1'b0; start_drv = 1'b0; ready_drv = 1'b0;
    step();
  endtask

  task automatic test_basic_word();
    sel16 = 1'b0; val12 = 12'hABC;
    set_expect(16'h0ABC, 2);
    run_word(1, 0, 1, 80);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout got=no done want=done"); end
    total++;
    if (got_q !== exp_q) begin bad++; $display("FAIL basic_bytes got=%p want=%p", got_q, exp_q); end
    total++;
    if (en_first !== 1) begin bad++; $display("FAIL basic_enable_latency got=%0d want=1", en_first); end
    total++;
    if (valid_first !== FILL_CYC + 2) begin bad++; $display("FAIL basic_valid_latency got=%0d want=%0d", valid_first, FILL_CYC + 2); end
    total++;
    if (done_at !== valid_first + exp_q.size() || done_cnt !== 1) begin
      bad++;
      $display("FAIL basic_done got at=%0d cnt=%0d want at=%0d cnt=1", done_at, done_cnt, FILL_CYC + 2 + exp_q.size());
    end
    total++;
    if (busy_last !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy_last); end
  endtask

  task automatic test_stall();
    sel16 = 1'b0; val12 = 12'hABC;
    set_expect(16'h0ABC, 2);
    run_word(1, 1, 1, 120);
    total++;
    if (got_q !== exp_q) begin bad++; $display("FAIL stall_bytes got=%p want=%p", got_q, exp_q); end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d changes want=0", stall_bad); end
    total++;
    if (done_cnt !== 1 || done_at !== FILL_CYC + 2 + 2 * exp_q.size()) begin
      bad++;
      $display("FAIL stall_done got at=%0d cnt=%0d want at=%0d cnt=1", done_at, done_cnt, FILL_CYC + 2 + 2 * exp_q.size());
    end
  endtask

  task automatic test_start_held();
    sel16 = 1'b0; val12 = 12'h5E7;
    set_expect(16'h05E7, 2);
    run_word(20, 0, 15, 100);
    total++;
    if (got_q !== exp_q) begin bad++; $display("FAIL held_bytes got=%p want=%p", got_q, exp_q); end
    total++;
    if (done_cnt !== 1 || en_after_done !== 0) begin
      bad++;
      $display("FAIL held_single got done=%0d refills=%0d want done=1 refills=0", done_cnt, en_after_done);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    int   dcnt, vcnt;
    sel16 = 1'b0; val12 = 12'hABC;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      start_drv = (i == 0);
      ready_drv = 1'b1;
      if (obs_valid) found = 1'b1;
      step();
    end
    reset = 1'b1; start_drv = 1'b0; ready_drv = 1'b0;
    total++;
    if (!found) begin bad++; $display("FAIL midreset_first_byte got=none want=transfer"); end
    step();
    total++;
    if (obs_valid !== 1'b0 || obs_en !== 1'b0 || obs_busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort got v/en/busy=%b%b%b want 000", obs_valid, obs_en, obs_busy);
    end
    reset = 1'b0;
    dcnt = 0; vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (obs_done) dcnt++;
      if (obs_valid) vcnt++;
      step();
    end
    total++;
    if (dcnt !== 0 || vcnt !== 0) begin bad++; $display("FAIL midreset_quiet got done=%0d valid=%0d want 0 0", dcnt, vcnt); end
    set_expect(16'h0ABC, 2);
    run_word(1, 0, 1, 80);
    total++;
    if (got_q !== exp_q || done_cnt !== 1) begin
      bad++;
      $display("FAIL midreset_restart got=%p done=%0d want=%p done=1", got_q, done_cnt, exp_q);
    end
  endtask

  task automatic test_header_word();
    sel16 = 1'b0; val12 = 12'h123;
    set_expect(16'h0123, 2);
    run_word(1, 0, 1, 80);
    total++;
    if (got_q !== exp_q || done_cnt !== 1) begin
      bad++;
      $display("FAIL hdr_word got=%p done=%0d want=%p done=1", got_q, done_cnt, exp_q);
    end
  endtask

  task automatic test_back_to_back16();
    sel16 = 1'b1; val16 = 16'hFFFF;
    set_expect(16'hFFFF, 2);
    run_word(1, 0, 0, 80);
    total++;
    if (got_q !== exp_q || done_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_first got=%p done=%0d want=%p done=1", got_q, done_cnt, exp_q);
    end
    run_word(1, 0, 1, 80);
    total++;
    if (got_q !== exp_q || done_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_second got=%p done=%0d want=%p done=1", got_q, done_cnt, exp_q);
    end
    total++;
    if (en_first !== 1 || full_at0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pool_clear got en_first=%0d full=%b want 1 0", en_first, full_at0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_stall();
    test_start_held();
    test_reset_mid();
    test_header_word();
    test_back_to_back16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
